writeback_port_arbiter: RTL and testbench
=========================================

# writeback_port_arbiter

Drives the single write port of the MIPS register file from two producers: the in-order pipeline write-back stage (fixed priority, never stalled) and a long-latency unit (multiply/divide, slow loads) through a small pending-write queue. Sits between the WB stage and the register file write port. It also gives decode a hazard flag per read port for queued writes and a bypass for the write in flight.

## Interface
Parameters:
- N, 32, data width
- DEPTH, 4, pending-queue entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- wb_reg_write  in  1  pipeline write request
- wb_write_register  in  5  pipeline destination
- wb_write_data  in  N  pipeline data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  queue can accept
- lu_write_register  in  5  long-latency destination
- lu_write_data  in  N  long-latency data
- RegWrite  out  1  register file write enable (registered)
- WriteRegister  out  5  register file destination (registered)
- WriteData  out  N  register file data (registered)
- ReadRegister1, ReadRegister2  in  5 each  decode read addresses
- hazard1, hazard2  out  1 each  read address matches a valid queued entry
- bypass1, bypass2  out  1 each  read address matches the in-flight write
- bypass_data1, bypass_data2  out  N each  WriteData when the matching bypass is set, else 0
- occupancy  out  $clog2(DEPTH)+1  queued entries, valid or killed

## Operation
- wb_active = wb_reg_write && wb_write_register != 0.
- Push: lu_valid && lu_ready. lu_ready = occupancy < DEPTH. It ignores a same-cycle pop. A push to register 0 is accepted and its entry stored invalid.
- Kill: when wb_active, every queued valid entry with destination == wb_write_register is invalidated, because the pipeline write is younger. An entry pushed in the same cycle with that destination is also stored invalid.
- Output stage selection, each cycle:
  - If wb_active: load {1, wb dest, wb data}.
  - Else if the queue is not empty: pop the head and load {head.valid, head dest, head data}.
  - Else: load RegWrite = 0. WriteRegister and WriteData hold their values.
- The queue pops only when wb is not active, so invalid entries drain one per idle cycle.
- hazardK = OR over valid entries of (dest == ReadRegisterK), forced to 0 when ReadRegisterK == 0. It is computed combinationally from queue state only.
- bypassK = RegWrite && WriteRegister == ReadRegisterK && ReadRegisterK != 0.
- Reset (any time, including mid-drain) clears the queue, all valid bits, the pointers and the outputs, and discards pending writes.

## Timing
- Reset values: RegWrite 0, WriteRegister 0, WriteData 0, occupancy 0, lu_ready 1, all hazard and bypass outputs 0.
- WB request in cycle T produces RegWrite = 1 in cycle T+1.
- A long-latency push at edge T can appear on the write port no earlier than cycle T+2, and only if wb is idle in cycle T+1.
- Full queue: lu_ready is 0 for the whole cycle, including a cycle in which a pop occurs. It rises the cycle after the pop.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by occupancy.
- Simultaneous push and pop: occupancy is unchanged, and the head and tail advance together.

## Structure
- Shared package: REG_ADDR_W = 5, the zero-register constant, and the queue entry typedef {valid, dest[4:0], data[N-1:0]}.
- One sub-module, wb_pending_queue:
  - circular buffer with per-entry valid bits;
  - kill-by-destination port;
  - two-port destination match outputs for the hazard flags.
- The top level holds the priority select, the output register and the bypass compare.

## Test plan
- Reset, then wb write to reg 8 with data 0xA5 -> next cycle RegWrite=1, WriteRegister=8, WriteData=0xA5; bypass1=1 and bypass_data1=0xA5 with ReadRegister1=8.
- Push lu writes to regs 3, 4, 5 with wb idle -> writes appear on consecutive cycles starting 2 cycles after the first push; hazard2 with ReadRegister2=5 clears once reg 5's entry is popped; occupancy returns to 0.
- Fill DEPTH=4 while wb is busy every cycle -> lu_ready=0 at occupancy 4 and no write reaches the port from the queue; release wb -> queue drains in FIFO order and lu_ready rises one cycle after the first pop.
- Queue holds reg 9 = 0x11, then wb writes reg 9 = 0x22 -> entry killed, hazard on reg 9 drops, the killed pop yields RegWrite=0, and reg 9's final written value is 0x22.
- Push and wb both target reg 0 -> no RegWrite; the entry counts in occupancy and drains silently; hazard and bypass stay 0 for ReadRegister=0.
- Assert reset with 3 entries queued and RegWrite=1 -> all outputs go to reset values immediately with no clock edge, and no queued write appears after release.

Source files
------------

// File: rtl/writeback_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Queue tags carry the valid/destination pair; the data words sit in a parallel array.
package writeback_port_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Queue entry {valid, dest}; data[N-1:0] lives in a width-parameterised array
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
    } entryTag_t;

    function automatic logic tagMatch(entryTag_t tag, logic [REG_ADDR_W-1:0] addr);
        return tag.valid && (tag.dest == addr) && (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_pending_queue.sv
// Circular pending-write queue for long-latency results, with per-entry valid bits,
// kill-by-destination and two read-address match ports for decode hazard detection.
module wb_pending_queue
    import writeback_port_arbiter_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [REG_ADDR_W-1:0]   pushDest,
    input  logic [N-1:0]            pushData,
    input  logic                    pop,
    input  logic                    killEn,
    input  logic [REG_ADDR_W-1:0]   killDest,
    input  logic [REG_ADDR_W-1:0]   readReg1,
    input  logic [REG_ADDR_W-1:0]   readReg2,
    output logic                    headValid,
    output logic [REG_ADDR_W-1:0]   headDest,
    output logic [N-1:0]            headData,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    full,
    output logic                    empty,
    output logic                    match1,
    output logic                    match2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entryTag_t          tagsQ [DEPTH];
    entryTag_t          tagsD [DEPTH];
    logic [N-1:0]       dataQ [DEPTH];
    logic [PTR_W-1:0]   headQ, headD;
    logic [PTR_W-1:0]   tailQ, tailD;
    logic [CNT_W-1:0]   countQ, countD;

    always_comb begin
        tagsD = tagsQ;
        headD = headQ;
        tailD = tailQ;
        countD = countQ;
        // A valid pipeline write makes any older queued write to the same register stale
        for (int i = 0; i < DEPTH; i++) begin
            if (killEn && tagsQ[i].valid && (tagsQ[i].dest == killDest)) begin
                tagsD[i].valid = 1'b0;
            end
        end
        if (pop) begin
            tagsD[headQ].valid = 1'b0;
            headD = headQ + 1'b1;
        end
        if (push) begin
            tagsD[tailQ].valid = (pushDest != ZERO_REG) && !(killEn && (pushDest == killDest));
            tagsD[tailQ].dest  = pushDest;
            tailD = tailQ + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   countD = countQ + 1'b1;
            2'b01:   countD = countQ - 1'b1;
            default: countD = countQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tagsQ[i] <= '0;
                dataQ[i] <= '0;
            end
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
        end else begin
            tagsQ  <= tagsD;
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
            if (push) begin
                dataQ[tailQ] <= pushData;
            end
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match1 = match1 | tagMatch(tagsQ[i], readReg1);
            match2 = match2 | tagMatch(tagsQ[i], readReg2);
        end
    end

    assign headValid = tagsQ[headQ].valid;
    assign headDest  = tagsQ[headQ].dest;
    assign headData  = dataQ[headQ];
    assign occupancy = countQ;
    assign full      = (countQ == CNT_W'(DEPTH));
    assign empty     = (countQ == '0);

endmodule

// File: rtl/writeback_port_arbiter.sv
// Register-file write-port arbiter: the WB stage has fixed priority, long-latency results
// wait in a pending queue and drain on idle cycles. Also produces decode hazard/bypass flags.
module writeback_port_arbiter
    import writeback_port_arbiter_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_reg_write,
    input  logic [REG_ADDR_W-1:0]   wb_write_register,
    input  logic [N-1:0]            wb_write_data,
    input  logic                    lu_valid,
    output logic                    lu_ready,
    input  logic [REG_ADDR_W-1:0]   lu_write_register,
    input  logic [N-1:0]            lu_write_data,
    output logic                    RegWrite,
    output logic [REG_ADDR_W-1:0]   WriteRegister,
    output logic [N-1:0]            WriteData,
    input  logic [REG_ADDR_W-1:0]   ReadRegister1,
    input  logic [REG_ADDR_W-1:0]   ReadRegister2,
    output logic                    hazard1,
    output logic                    hazard2,
    output logic                    bypass1,
    output logic                    bypass2,
    output logic [N-1:0]            bypass_data1,
    output logic [N-1:0]            bypass_data2,
    output logic [$clog2(DEPTH):0]  occupancy
);

    logic                  wbActive;
    logic                  push;
    logic                  pop;
    logic                  queueFull;
    logic                  queueEmpty;
    logic                  headValid;
    logic [REG_ADDR_W-1:0] headDest;
    logic [N-1:0]          headData;
    logic                  regWriteD;
    logic [REG_ADDR_W-1:0] writeRegisterD;
    logic [N-1:0]          writeDataD;

    assign wbActive = wb_reg_write && (wb_write_register != ZERO_REG);
    // Ready is based on current occupancy only, so a full queue stays closed during its pop
    assign lu_ready = !queueFull;
    assign push     = lu_valid && lu_ready;
    assign pop      = !wbActive && !queueEmpty;

    wb_pending_queue #(
        .N     (N),
        .DEPTH (DEPTH)
    ) uQueue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pushDest  (lu_write_register),
        .pushData  (lu_write_data),
        .pop       (pop),
        .killEn    (wbActive),
        .killDest  (wb_write_register),
        .readReg1  (ReadRegister1),
        .readReg2  (ReadRegister2),
        .headValid (headValid),
        .headDest  (headDest),
        .headData  (headData),
        .occupancy (occupancy),
        .full      (queueFull),
        .empty     (queueEmpty),
        .match1    (hazard1),
        .match2    (hazard2)
    );

    always_comb begin
        regWriteD      = 1'b0;
        writeRegisterD = WriteRegister;
        writeDataD     = WriteData;
        if (wbActive) begin
            regWriteD      = 1'b1;
            writeRegisterD = wb_write_register;
            writeDataD     = wb_write_data;
        end else if (!queueEmpty) begin
            // Killed entries still pop, but with the write enable low
            regWriteD      = headValid;
            writeRegisterD = headDest;
            writeDataD     = headData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite      <= regWriteD;
            WriteRegister <= writeRegisterD;
            WriteData     <= writeDataD;
        end
    end

    assign bypass1      = RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_REG);
    assign bypass2      = RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_REG);
    assign bypass_data1 = bypass1 ? WriteData : '0;
    assign bypass_data2 = bypass2 ? WriteData : '0;

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Directed self-checking bench for writeback_port_arbiter (N=32, DEPTH=4).
module tb_writeback_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_reg_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_write_register;
    logic [31:0] lu_write_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        hazard1;
    logic        hazard2;
    logic        bypass1;
    logic        bypass2;
    logic [31:0] bypass_data1;
    logic [31:0] bypass_data2;
    logic [2:0]  occupancy;

    int nChecks = 0;
    int nFails  = 0;

    writeback_port_arbiter #(
        .N     (32),
        .DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_reg_write      (wb_reg_write),
        .wb_write_register (wb_write_register),
        .wb_write_data     (wb_write_data),
        .lu_valid          (lu_valid),
        .lu_ready          (lu_ready),
        .lu_write_register (lu_write_register),
        .lu_write_data     (lu_write_data),
        .RegWrite          (RegWrite),
        .WriteRegister     (WriteRegister),
        .WriteData         (WriteData),
        .ReadRegister1     (ReadRegister1),
        .ReadRegister2     (ReadRegister2),
        .hazard1           (hazard1),
        .hazard2           (hazard2),
        .bypass1           (bypass1),
        .bypass2           (bypass2),
        .bypass_data1      (bypass_data1),
        .bypass_data2      (bypass_data2),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setWb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write      = en;
        wb_write_register = r;
        wb_write_data     = d;
    endtask

    task automatic setLu(input logic en, input logic [4:0] r, input logic [31:0] d);
        lu_valid          = en;
        lu_write_register = r;
        lu_write_data     = d;
    endtask

    task automatic checkPort(input string tag, input logic we, input logic [4:0] r,
                             input logic [31:0] d);
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(we));
        check({tag, ".WriteRegister"}, 32'(WriteRegister), 32'(r));
        check({tag, ".WriteData"}, WriteData, d);
    endtask

    initial begin
        reset = 1'b0;
        setWb(1'b0, 5'd0, 32'h0);
        setLu(1'b0, 5'd0, 32'h0);
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        #12;
        checkPort("rst", 1'b0, 5'd0, 32'h0);
        check("rst.occupancy", 32'(occupancy), 32'd0);
        check("rst.lu_ready", 32'(lu_ready), 32'd1);
        check("rst.flags", {28'h0, hazard1, hazard2, bypass1, bypass2}, 32'h0);
        @(negedge clk) reset = 1'b1;
        step();

        // WB write and bypass
        setWb(1'b1, 5'd8, 32'hA5);
        step();
        setWb(1'b0, 5'd0, 32'h0);
        ReadRegister1 = 5'd8;
        #1;
        checkPort("wb8", 1'b1, 5'd8, 32'hA5);
        check("wb8.bypass1", 32'(bypass1), 32'd1);
        check("wb8.bypass_data1", bypass_data1, 32'hA5);
        check("wb8.bypass2", 32'(bypass2), 32'd0);
        step();
        checkPort("wb8.idle", 1'b0, 5'd8, 32'hA5);
        check("wb8.idle.bypass1", 32'(bypass1), 32'd0);

        // Long-latency pushes drain on consecutive idle cycles
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd5;
        setLu(1'b1, 5'd3, 32'h33);
        step();
        check("lu.occ1", 32'(occupancy), 32'd1);
        check("lu.noWriteYet", 32'(RegWrite), 32'd0);
        setLu(1'b1, 5'd4, 32'h44);
        step();
        checkPort("lu3", 1'b1, 5'd3, 32'h33);
        setLu(1'b1, 5'd5, 32'h55);
        step();
        checkPort("lu4", 1'b1, 5'd4, 32'h44);
        check("lu.hazard2.set", 32'(hazard2), 32'd1);
        setLu(1'b0, 5'd0, 32'h0);
        step();
        checkPort("lu5", 1'b1, 5'd5, 32'h55);
        check("lu.hazard2.clr", 32'(hazard2), 32'd0);
        check("lu.occ0", 32'(occupancy), 32'd0);
        step();
        check("lu.idle", 32'(RegWrite), 32'd0);

        // Fill the queue behind a busy WB stage
        setWb(1'b1, 5'd20, 32'h100);
        for (int i = 0; i < 4; i++) begin
            setLu(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            step();
            check("fill.occ", 32'(occupancy), 32'(i + 1));
            checkPort("fill.wb", 1'b1, 5'd20, 32'h100);
        end
        check("fill.lu_ready", 32'(lu_ready), 32'd0);
        setLu(1'b1, 5'd14, 32'hA4);
        step();
        check("full.occ", 32'(occupancy), 32'd4);
        check("full.lu_ready", 32'(lu_ready), 32'd0);
        checkPort("full.wb", 1'b1, 5'd20, 32'h100);
        setWb(1'b0, 5'd0, 32'h0);
        #1;
        check("popcyc.lu_ready", 32'(lu_ready), 32'd0);
        step();
        checkPort("drain10", 1'b1, 5'd10, 32'hA0);
        check("drain.occ3", 32'(occupancy), 32'd3);
        check("drain.lu_ready", 32'(lu_ready), 32'd1);
        step();
        setLu(1'b0, 5'd0, 32'h0);
        checkPort("drain11", 1'b1, 5'd11, 32'hA1);
        check("drain.occ3b", 32'(occupancy), 32'd3);
        for (int i = 2; i < 5; i++) begin
            step();
            checkPort("drainN", 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            check("drainN.occ", 32'(occupancy), 32'(4 - i));
        end
        step();
        check("drain.idle", 32'(RegWrite), 32'd0);

        // Kill a queued write with a younger pipeline write
        setWb(1'b1, 5'd21, 32'h55);
        setLu(1'b1, 5'd9, 32'h11);
        step();
        setLu(1'b0, 5'd0, 32'h0);
        ReadRegister1 = 5'd9;
        #1;
        check("kill.hazard1.set", 32'(hazard1), 32'd1);
        check("kill.occ1", 32'(occupancy), 32'd1);
        setWb(1'b1, 5'd9, 32'h22);
        step();
        checkPort("kill.wb9", 1'b1, 5'd9, 32'h22);
        check("kill.hazard1.clr", 32'(hazard1), 32'd0);
        check("kill.occ1b", 32'(occupancy), 32'd1);
        setWb(1'b0, 5'd0, 32'h0);
        step();
        check("kill.pop.RegWrite", 32'(RegWrite), 32'd0);
        check("kill.pop.bypass1", 32'(bypass1), 32'd0);
        check("kill.occ0", 32'(occupancy), 32'd0);

        // Register 0 from both producers
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        setWb(1'b1, 5'd0, 32'h77);
        setLu(1'b1, 5'd0, 32'h66);
        step();
        setWb(1'b0, 5'd0, 32'h0);
        setLu(1'b0, 5'd0, 32'h0);
        #1;
        check("r0.RegWrite", 32'(RegWrite), 32'd0);
        check("r0.occ", 32'(occupancy), 32'd1);
        check("r0.flags", {28'h0, hazard1, hazard2, bypass1, bypass2}, 32'h0);
        step();
        check("r0.drain.RegWrite", 32'(RegWrite), 32'd0);
        check("r0.drain.occ", 32'(occupancy), 32'd0);

        // Asynchronous reset with writes pending
        setWb(1'b1, 5'd22, 32'h99);
        for (int i = 0; i < 3; i++) begin
            setLu(1'b1, 5'(6 + i), 32'hC0 + 32'(i));
            step();
        end
        setWb(1'b0, 5'd0, 32'h0);
        setLu(1'b0, 5'd0, 32'h0);
        ReadRegister1 = 5'd6;
        check("prerst.occ", 32'(occupancy), 32'd3);
        check("prerst.RegWrite", 32'(RegWrite), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkPort("arst", 1'b0, 5'd0, 32'h0);
        check("arst.occ", 32'(occupancy), 32'd0);
        check("arst.lu_ready", 32'(lu_ready), 32'd1);
        check("arst.hazard1", 32'(hazard1), 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst.RegWrite", 32'(RegWrite), 32'd0);
            check("postrst.occ", 32'(occupancy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
